// File: rtl/dac_spi_tx_pkg.sv
// Shared definitions for the MCP4911-class DAC serialiser: FSM states,
// frame geometry, default configuration nibble and the frame builder.
package dac_spi_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int FRAME_W = 16;
  localparam int DATA_W  = 10;

  // write=0, BUF=0, GA=1 (1x gain), SHDN=1 (output active)
  localparam logic [3:0] CFG_BITS_DEF = 4'b0011;

  // Index of the final SCK half-period in a 16-bit frame (32 half-periods).
  localparam logic [4:0] LAST_HALF = 5'd31;

  // Command word: config nibble, DAC code, two don't-care LSBs sent as 0.
  function automatic logic [FRAME_W-1:0] build_frame(input logic [3:0]        cfg,
                                                     input logic [DATA_W-1:0] code);
    return {cfg, code, 2'b00};
  endfunction

endpackage

// File: rtl/dac_spi_tx_sck_divider.sv
// Half-period tick generator: o_tick is high for one cycle at the end of
// every CLK_DIV enabled cycles. Clearing returns the count to zero.
module sck_divider #(
  parameter int CLK_DIV = 25
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0]   TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Count enabled cycles, wrapping at the terminal count.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == TERM);

endmodule

// File: rtl/dac_spi_tx.sv
// Serialises 10-bit DAC codes into 16-bit SPI write frames (mode 0,0),
// then pulses LDAC. A one-deep pending register holds a sample that
// arrives while a frame is in flight; a newer sample replaces it.
module dac_spi_tx
  import dac_spi_tx_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter logic [3:0] CFG_BITS = CFG_BITS_DEF
) (
  input  logic              sysclk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              dac_cs,
  output logic              dac_sck,
  output logic              dac_sdi,
  output logic              dac_ld
);

  state_t             r_state,  w_state;
  logic [FRAME_W-1:0] r_shift,  w_shift;
  logic [4:0]         r_hcnt,   w_hcnt;
  logic               r_pend_vld, w_pend_vld;
  logic [DATA_W-1:0]  r_pend,   w_pend;
  logic               r_ovr,    w_ovr;
  logic               r_sck,    w_sck;
  logic               r_sdi,    w_sdi;
  logic               r_busy, r_done, r_cs, r_ld;

  logic               w_div_en;
  logic               w_tick;
  logic               w_start;
  logic [DATA_W-1:0]  w_start_data;

  // The divider times both the SCK half-periods and the LDAC low pulse.
  assign w_div_en = (r_state == ST_SHIFT) || (r_state == ST_LATCH);

  sck_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .i_clk   (sysclk),
    .i_rst_n (rst_n),
    .i_en    (w_div_en),
    .i_clr   (!w_div_en),
    .o_tick  (w_tick)
  );

  // Next-state, pending-register and serial-pin decisions.
  always_comb begin
    w_state      = r_state;
    w_shift      = r_shift;
    w_hcnt       = r_hcnt;
    w_pend_vld   = r_pend_vld;
    w_pend       = r_pend;
    w_ovr        = 1'b0;
    w_sck        = r_sck;
    w_sdi        = r_sdi;
    w_start      = 1'b0;
    w_start_data = data_in;

    // While a frame is active, a new sample is parked; replacing a parked one flags overrun.
    if ((r_state != ST_IDLE) && load) begin
      w_pend     = data_in;
      w_pend_vld = 1'b1;
      w_ovr      = r_pend_vld;
    end

    case (r_state)
      ST_IDLE: begin
        if (load) begin
          w_start      = 1'b1;
          w_start_data = data_in;
        end else if (r_pend_vld) begin
          w_start      = 1'b1;
          w_start_data = r_pend;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          w_hcnt = r_hcnt + 5'd1;
          if (!r_sck) begin
            w_sck = 1'b1;
          end else begin
            // Falling edge: present the next bit for the DAC's next rising-edge sample.
            w_sck   = 1'b0;
            w_shift = r_shift << 1;
            w_sdi   = r_shift[FRAME_W-2];
            if (r_hcnt == LAST_HALF) begin
              w_sdi   = 1'b0;
              w_hcnt  = 5'd0;
              w_state = ST_LATCH;
            end
          end
        end
      end
      ST_LATCH: begin
        if (w_tick) begin
          w_state = ST_DONE;
        end
      end
      ST_DONE: begin
        // A sample loaded in this very cycle is newer than anything parked.
        if (load) begin
          w_start      = 1'b1;
          w_start_data = data_in;
        end else if (r_pend_vld) begin
          w_start      = 1'b1;
          w_start_data = r_pend;
        end else begin
          w_state = ST_IDLE;
        end
      end
    endcase

    if (w_start) begin
      w_state    = ST_SHIFT;
      w_shift    = build_frame(CFG_BITS, w_start_data);
      w_sdi      = CFG_BITS[3];
      w_sck      = 1'b0;
      w_hcnt     = 5'd0;
      w_pend_vld = 1'b0;
    end
  end

  // Control state and registered pins; reset aborts any frame on the next edge.
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hcnt     <= 5'd0;
      r_pend_vld <= 1'b0;
      r_ovr      <= 1'b0;
      r_sck      <= 1'b0;
      r_sdi      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cs       <= 1'b1;
      r_ld       <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_hcnt     <= w_hcnt;
      r_pend_vld <= w_pend_vld;
      r_ovr      <= w_ovr;
      r_sck      <= w_sck;
      r_sdi      <= w_sdi;
      r_busy     <= (w_state != ST_IDLE);
      r_done     <= (w_state == ST_DONE);
      r_cs       <= (w_state != ST_SHIFT);
      r_ld       <= (w_state != ST_LATCH);
    end
  end

  // Frame and parked-sample data; qualified by state and r_pend_vld, so never reset.
  always_ff @(posedge sysclk) begin
    r_shift <= w_shift;
    r_pend  <= w_pend;
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign overrun = r_ovr;
  assign dac_cs  = r_cs;
  assign dac_sck = r_sck;
  assign dac_sdi = r_sdi;
  assign dac_ld  = r_ld;

endmodule

// File: tb/tb_dac_spi_tx.sv
`timescale 1ns/1ps
module tb_dac_spi_tx;

  localparam int D   = 2;
  localparam int LAT = 33 * D + 1;
  localparam int D25 = 25;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  logic       rst_n;
  logic       ld2, ld25;
  logic [9:0] dat2, dat25;
  logic       busy2, done2, ovr2, cs2, sck2, sdi2, ldac2;
  logic       busy25, done25, ovr25, cs25, sck25, sdi25, ldac25;

  dac_spi_tx #(.CLK_DIV(D)) dut2 (
    .sysclk(sysclk), .rst_n(rst_n), .load(ld2), .data_in(dat2),
    .busy(busy2), .done(done2), .overrun(ovr2),
    .dac_cs(cs2), .dac_sck(sck2), .dac_sdi(sdi2), .dac_ld(ldac2)
  );

  dac_spi_tx #(.CLK_DIV(D25)) dut25 (
    .sysclk(sysclk), .rst_n(rst_n), .load(ld25), .data_in(dat25),
    .busy(busy25), .done(done25), .overrun(ovr25),
    .dac_cs(cs25), .dac_sck(sck25), .dac_sdi(sdi25), .dac_ld(ldac25)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model for the CLK_DIV=2 instance ----------------
  // Busy interval of every frame is LAT cycles: 32*D shift, D latch, 1 done.
  int          m_rem = 0;
  bit          m_pend_vld = 1'b0;
  logic [9:0]  m_pend = '0;
  logic [15:0] m_frame = '0;
  bit          m_ovr = 1'b0;
  logic [15:0] exp_q[$];

  function automatic logic [15:0] frame_of(input logic [9:0] d);
    return 16'h3000 + 16'(d) * 16'd4;
  endfunction

  always @(posedge sysclk) begin
    cyc++;
    if (rst_n !== 1'b1) begin
      m_rem = 0; m_pend_vld = 1'b0; m_ovr = 1'b0; exp_q.delete();
    end else begin
      m_ovr = 1'b0;
      if (m_rem == 0) begin
        if (ld2) begin
          m_frame = frame_of(dat2); m_rem = LAT; exp_q.push_back(m_frame);
        end
      end else begin
        if (ld2) begin
          m_ovr = m_pend_vld; m_pend = dat2; m_pend_vld = 1'b1;
        end
        if (m_rem == 1) begin
          if (m_pend_vld) begin
            m_pend_vld = 1'b0; m_frame = frame_of(m_pend); m_rem = LAT; exp_q.push_back(m_frame);
          end else begin
            m_rem = 0;
          end
        end else begin
          m_rem--;
        end
      end
    end
  end

  // ---------------- SPI capture (DAC side) ----------------
  logic [15:0] sh2 = '0, last_cap2 = '0, sh25 = '0;
  int          nb2 = 0, nb25 = 0, n_frames2 = 0, rise25 = 0;
  int          last_rise25 = -1, pmin25 = 0, pmax25 = 0;
  logic [15:0] cap_q[$];

  always @(negedge cs2) begin sh2 = '0; nb2 = 0; end
  always @(posedge sck2) if (cs2 === 1'b0) begin sh2 = {sh2[14:0], sdi2}; nb2++; end
  always @(posedge cs2) if (chk_en && nb2 == 16) begin
    cap_q.push_back(sh2); last_cap2 = sh2; n_frames2++;
  end

  always @(negedge cs25) begin sh25 = '0; nb25 = 0; last_rise25 = -1; pmin25 = 1000000; pmax25 = 0; end
  always @(posedge sck25) begin
    rise25++;
    if (cs25 === 1'b0) begin
      sh25 = {sh25[14:0], sdi25}; nb25++;
      if (last_rise25 >= 0) begin
        if (cyc - last_rise25 < pmin25) pmin25 = cyc - last_rise25;
        if (cyc - last_rise25 > pmax25) pmax25 = cyc - last_rise25;
      end
      last_rise25 = cyc;
    end
  end

  // ---------------- per-cycle pin comparison against the model ----------------
  int ovr_cnt2 = 0;
  always @(negedge sysclk) begin
    logic [6:0]  e;
    logic        e_shift, e_sck, e_sdi;
    int          k, hp;
    if (chk_en) begin
      e_shift = (m_rem >= D + 2);
      e_sck = 1'b0; e_sdi = 1'b0;
      if (e_shift) begin
        k  = LAT + 1 - m_rem;
        hp = (k - 1) / D;
        e_sck = (hp % 2 == 1);
        e_sdi = m_frame[15 - hp / 2];
      end
      e = {m_rem > 0, m_rem == 1, m_ovr, !e_shift, e_sck, e_sdi, !(m_rem >= 2 && m_rem <= D + 1)};
      check("pins2{busy,done,ovr,cs,sck,sdi,ld}", {busy2, done2, ovr2, cs2, sck2, sdi2, ldac2}, e);
      if (ovr2 === 1'b1) ovr_cnt2++;
      if (cap_q.size() > 0) begin
        if (exp_q.size() == 0) check("frame2_unexpected", cap_q.pop_front(), 32'hFFFF_FFFF);
        else                   check("frame2", cap_q.pop_front(), exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse2(input logic [9:0] d);
    @(posedge sysclk); #1; ld2 = 1'b1; dat2 = d;
    @(posedge sysclk); #1; ld2 = 1'b0;
  endtask

  task automatic pulse25(input logic [9:0] d);
    @(posedge sysclk); #1; ld25 = 1'b1; dat25 = d;
    @(posedge sysclk); #1; ld25 = 1'b0;
  endtask

  // Counts cycles from the load-sampling edge until done is seen high.
  task automatic wait_done(input int which, input int limit, output int n);
    logic d;
    n = 0;
    for (int i = 1; i <= limit; i++) begin
      @(negedge sysclk);
      d = (which == 2) ? done2 : done25;
      if (d === 1'b1) begin n = i; break; end
      @(posedge sysclk);
    end
    if (n == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle2();
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge sysclk);
      if (busy2 === 1'b0 && m_rem == 0) break;
    end
    if (i == 400) check("idle_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [9:0]  d;
    logic [15:0] f;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n, ob;
    tbl[0] = '{d: 10'h2A5, f: 16'h3A94};
    tbl[1] = '{d: 10'h000, f: 16'h3000};
    tbl[2] = '{d: 10'h3FF, f: 16'h3FFC};
    tbl[3] = '{d: 10'h155, f: 16'h3554};
    tbl[4] = '{d: 10'h2AA, f: 16'h3AA8};
    tbl[5] = '{d: 10'h001, f: 16'h3004};

    rst_n = 1'b0; ld2 = 1'b0; dat2 = '0; ld25 = 1'b0; dat25 = '0;
    @(posedge sysclk);
    chk_en = 1'b1;

    // Reset held for 5 cycles while load toggles: nothing may start.
    for (int i = 0; i < 5; i++) begin
      @(posedge sysclk); #1; ld2 = i[0]; ld25 = i[0]; dat2 = 10'(i * 77); dat25 = 10'h155;
      @(negedge sysclk);
      check("rst_pins2", {busy2, done2, ovr2, cs2, sck2, sdi2, ldac2}, 7'b0001001);
      check("rst_pins25", {busy25, done25, ovr25, cs25, sck25, sdi25, ldac25}, 7'b0001001);
    end
    @(posedge sysclk); #1; ld2 = 1'b0; ld25 = 1'b0; rst_n = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("rst_nothing_captured_busy", busy2, 1'b0);
    check("rst_nothing_captured_frames", n_frames2, 0);

    // Table-driven single frames with latency check.
    for (int i = 0; i < 6; i++) begin
      pulse2(tbl[i].d);
      wait_done(2, LAT + 20, n);
      check("latency2", n, LAT);
      check("table_frame", last_cap2, tbl[i].f);
      repeat (2) @(posedge sysclk);
    end

    // Back-to-back: second sample parked, starts with no idle gap.
    ob = ovr_cnt2;
    pulse2(10'h100);
    repeat (10) @(posedge sysclk);
    pulse2(10'h3FF);
    wait_done(2, 200, n);
    check("b2b_first", last_cap2, 16'h3400);
    @(negedge sysclk);
    check("b2b_no_gap", {busy2, cs2}, 2'b10);
    wait_done(2, 200, n);
    check("b2b_second", last_cap2, 16'h3FFC);
    check("b2b_overrun", ovr_cnt2 - ob, 0);
    wait_idle2();

    // Overwrite: 001 then 002 during one frame.
    ob = ovr_cnt2;
    pulse2(10'h050);
    repeat (5) @(posedge sysclk);
    pulse2(10'h001);
    repeat (5) @(posedge sysclk);
    pulse2(10'h002);
    wait_done(2, 200, n);
    check("ovw_overrun_once", ovr_cnt2 - ob, 1);
    wait_done(2, 200, n);
    check("ovw_frame", last_cap2, 16'h3008);
    wait_idle2();

    // Load in the DONE cycle goes to the next frame without a gap.
    pulse2(10'h0AB);
    for (int i = 0; i < 200; i++) begin
      @(posedge sysclk); #1;
      if (done2 === 1'b1) break;
    end
    ld2 = 1'b1; dat2 = 10'h3C3;
    @(posedge sysclk); #1; ld2 = 1'b0;
    @(negedge sysclk);
    check("done_load_starts", {busy2, cs2}, 2'b10);
    wait_done(2, 200, n);
    check("done_load_frame", last_cap2, frame_of(10'h3C3));
    wait_idle2();

    // Reset mid-SHIFT after 8 bits, then a clean frame.
    pulse2(10'h2A5);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge sysclk); #1;
      if (nb2 >= 8) begin n = 1; break; end
    end
    check("abort_reached_bit7", n, 1);
    rst_n = 1'b0;
    @(posedge sysclk);
    @(negedge sysclk);
    check("abort_pins", {cs2, ldac2, busy2, done2, sck2}, 5'b11000);
    rst_n = 1'b1;
    repeat (2) @(posedge sysclk);
    pulse2(10'h0F0);
    wait_done(2, LAT + 20, n);
    check("abort_latency", n, LAT);
    check("abort_next_frame", last_cap2, 16'h33C0);
    wait_idle2();

    // Default divider: SCK period and edge count.
    rise25 = 0;
    pulse25(10'h200);
    wait_done(25, 33 * D25 + 50, n);
    check("latency25", n, 33 * D25 + 1);
    check("frame25", sh25, 16'h3800);
    check("rises25_cs_low", nb25, 16);
    check("rises25_total", rise25, 16);
    check("sck25_period_min", pmin25, 2 * D25);
    check("sck25_period_max", pmax25, 2 * D25);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 90)) @(posedge sysclk);
      pulse2(10'($urandom_range(0, 1023)));
    end
    wait_idle2();
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check("exp_q_drained", exp_q.size(), 0);
    check("cap_q_drained", cap_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
